// File: rtl/regfile_wr_demux.sv
// Write side of the register block: one write-back stream is queued in a
// 2-entry pending-write FIFO and retired into NREGS registers under
// commit_en. Both read ports forward the newest pending data for their address.
module regfile_wr_demux #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [AWIDTH-1:0] i_wr_addr,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic              i_commit_en,
  input  logic [AWIDTH-1:0] i_rd_addr_a,
  output logic [DWIDTH-1:0] o_rd_data_a,
  input  logic [AWIDTH-1:0] i_rd_addr_b,
  output logic [DWIDTH-1:0] o_rd_data_b,
  output logic [1:0]        o_pend_cnt
);

  localparam int NREGS = 2 ** AWIDTH;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } pend_t;

  // Entry 0 is always the head (oldest), entry 1 the second slot.
  pend_t                          r_q0, r_q1;
  logic [1:0]                     r_cnt;
  logic [NREGS-1:0][DWIDTH-1:0]   r_regs;

  logic  w_push, w_pop;
  pend_t w_new;

  assign o_wr_ready = !i_rst && (r_cnt != 2'd2);
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = i_commit_en && (r_cnt != 2'd0);
  assign w_new      = '{addr: i_wr_addr, data: i_wr_data};
  assign o_pend_cnt = r_cnt;

  // Queue occupancy and entries; a pop shifts slot 1 into the head position.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= 2'd0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      case (r_cnt)
        2'd0: if (w_push) r_q0 <= w_new;
        2'd1: begin
          if (w_push && w_pop) r_q0 <= w_new;
          else if (w_push)     r_q1 <= w_new;
        end
        default: if (w_pop) r_q0 <= r_q1;
      endcase
    end
  end

  // Register array: head retires into its target; address 0 is never written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else if (w_pop && (r_q0.addr != '0)) begin
      r_regs[r_q0.addr] <= r_q0.data;
    end
  end

  // Read port A: zero register, then newest pending match, then the array.
  always_comb begin
    o_rd_data_a = r_regs[i_rd_addr_a];
    if (i_rd_addr_a == '0)                              o_rd_data_a = '0;
    else if (r_cnt == 2'd2 && r_q1.addr == i_rd_addr_a) o_rd_data_a = r_q1.data;
    else if (r_cnt != 2'd0 && r_q0.addr == i_rd_addr_a) o_rd_data_a = r_q0.data;
  end

  // Read port B: same priority as port A.
  always_comb begin
    o_rd_data_b = r_regs[i_rd_addr_b];
    if (i_rd_addr_b == '0)                              o_rd_data_b = '0;
    else if (r_cnt == 2'd2 && r_q1.addr == i_rd_addr_b) o_rd_data_b = r_q1.data;
    else if (r_cnt != 2'd0 && r_q0.addr == i_rd_addr_b) o_rd_data_b = r_q0.data;
  end

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Directed bench for regfile_wr_demux: queueing, forwarding, commit order,
// address-0 handling, simultaneous push/pop and mid-operation reset.
module tb_regfile_wr_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, wr_ready, commit_en;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic [1:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wr_demux #(.DWIDTH(32), .AWIDTH(5)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit_en(commit_en),
    .i_rd_addr_a(rd_addr_a), .o_rd_data_a(rd_data_a),
    .i_rd_addr_b(rd_addr_b), .o_rd_data_b(rd_data_b),
    .o_pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 0; commit_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    tick(); tick();
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %0b want 0", wr_ready); end
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL reset_pend got %0d want 0", pend_cnt); end
    rst = 1'b0; #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got %0b want 1", wr_ready); end
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = a[4:0]; rd_addr_b = 5'(31 - a); #1;
      checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        errors++; $display("FAIL reset_read addr %0d got a=%h b=%h want 0", a, rd_data_a, rd_data_b);
      end
    end
  endtask

  task automatic test_forward_commit();
    wr_valid = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr_a = 5;
    tick();
    wr_valid = 0;
    checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL fwd_pend got %0d want 1", pend_cnt); end
    checks++; if (rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_read got %h want deadbeef", rd_data_a); end
    commit_en = 1; tick(); commit_en = 0;
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL commit_pend got %0d want 0", pend_cnt); end
    checks++; if (rd_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_reg5 got %h want deadbeef", rd_data_a); end
  endtask

  task automatic test_same_addr();
    rd_addr_b = 3;
    wr_valid = 1; wr_addr = 3; wr_data = 32'h1; tick();
    wr_data = 32'h2; tick();
    // Still valid while full: must not be accepted.
    wr_addr = 4; wr_data = 32'h44; tick();
    wr_valid = 0;
    checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL same_pend2 got %0d want 2", pend_cnt); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL same_ready got %0b want 0", wr_ready); end
    checks++; if (rd_data_b !== 32'h2) begin errors++; $display("FAIL same_fwd_newest got %h want 2", rd_data_b); end
    commit_en = 1; tick(); commit_en = 0;
    checks++; if (rd_data_b !== 32'h2 || pend_cnt !== 2'd1) begin
      errors++; $display("FAIL same_commit1 got data=%h pend=%0d want 2/1", rd_data_b, pend_cnt);
    end
    commit_en = 1; tick(); commit_en = 0;
    rd_addr_a = 4; #1;
    checks++; if (rd_data_b !== 32'h2 || pend_cnt !== 2'd0) begin
      errors++; $display("FAIL same_commit2 got data=%h pend=%0d want 2/0", rd_data_b, pend_cnt);
    end
    checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL full_drop reg4 got %h want 0", rd_data_a); end
  endtask

  task automatic test_addr0();
    rd_addr_a = 0;
    wr_valid = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; tick(); wr_valid = 0;
    checks++; if (rd_data_a !== 32'h0 || pend_cnt !== 2'd1) begin
      errors++; $display("FAIL addr0_pend got data=%h pend=%0d want 0/1", rd_data_a, pend_cnt);
    end
    commit_en = 1; tick(); commit_en = 0;
    checks++; if (rd_data_a !== 32'h0 || pend_cnt !== 2'd0) begin
      errors++; $display("FAIL addr0_commit got data=%h pend=%0d want 0/0", rd_data_a, pend_cnt);
    end
  endtask

  task automatic test_simul();
    rd_addr_a = 7; rd_addr_b = 8;
    wr_valid = 1; wr_addr = 7; wr_data = 32'hA; tick();
    wr_addr = 8; wr_data = 32'hB; commit_en = 1; tick();
    wr_valid = 0; commit_en = 0;
    checks++; if (pend_cnt !== 2'd1) begin errors++; $display("FAIL simul_pend got %0d want 1", pend_cnt); end
    checks++; if (rd_data_a !== 32'hA) begin errors++; $display("FAIL simul_reg7 got %h want a", rd_data_a); end
    checks++; if (rd_data_b !== 32'hB) begin errors++; $display("FAIL simul_fwd8 got %h want b", rd_data_b); end
    commit_en = 1; tick(); commit_en = 0;
    checks++; if (rd_data_b !== 32'hB || pend_cnt !== 2'd0) begin
      errors++; $display("FAIL simul_drain got data=%h pend=%0d want b/0", rd_data_b, pend_cnt);
    end
  endtask

  task automatic test_no_bypass();
    rd_addr_a = 9;
    wr_valid = 1; wr_addr = 9; wr_data = 32'h55; commit_en = 1; #1;
    checks++; if (rd_data_a !== 32'h0) begin errors++; $display("FAIL no_bypass_read got %h want 0", rd_data_a); end
    tick(); wr_valid = 0; commit_en = 0;
    checks++; if (pend_cnt !== 2'd1 || rd_data_a !== 32'h55) begin
      errors++; $display("FAIL no_bypass_commit got pend=%0d data=%h want 1/55", pend_cnt, rd_data_a);
    end
    commit_en = 1; tick(); commit_en = 0;
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL no_bypass_drain got %0d want 0", pend_cnt); end
  endtask

  task automatic test_reset_mid();
    wr_valid = 1; wr_addr = 13; wr_data = 32'h13; tick();
    wr_addr = 14; wr_data = 32'h14; tick(); wr_valid = 0;
    checks++; if (pend_cnt !== 2'd2) begin errors++; $display("FAIL mid_pend_pre got %0d want 2", pend_cnt); end
    commit_en = 1; rst = 1; tick(); rst = 0; commit_en = 0;
    checks++; if (pend_cnt !== 2'd0) begin errors++; $display("FAIL mid_pend got %0d want 0", pend_cnt); end
    rd_addr_a = 13; rd_addr_b = 14; #1;
    checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      errors++; $display("FAIL mid_leak got a=%h b=%h want 0", rd_data_a, rd_data_b);
    end
    rd_addr_a = 5; rd_addr_b = 3; #1;
    checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      errors++; $display("FAIL mid_regs got r5=%h r3=%h want 0", rd_data_a, rd_data_b);
    end
  endtask

  initial begin
    test_reset();
    test_forward_commit();
    test_same_addr();
    test_addr0();
    test_simul();
    test_no_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
